range_finder_mt: RTL and testbench

Parametrised successor to the team's range finder: tracks the minimum and maximum of a sampled data stream between a `go` and a `finish` strobe. On `finish` it reports range, min, max and sample count, with selectable signed/unsigned comparison. It sits directly behind the input pins in the top-level wrapper and drives status and result outputs.

---
 rtl/range_finder_mt_if.sv | 29 ++
 rtl/range_finder_mt.sv | 133 +++++++++++++
 tb/tb_range_finder_mt.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/range_finder_mt_if.sv
// range_finder_mt_if: groups the strobe, sample and result signals of
// range_finder_mt. The master side drives the run control and sample bus,
// the slave side (the range finder) returns status and results.
interface range_finder_mt_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             go;
    logic             finish;
    logic             signed_mode;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] range;
    logic [WIDTH-1:0] min_out;
    logic [WIDTH-1:0] max_out;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             busy;
    logic             error;

    modport master (
        output go, finish, signed_mode, data_in,
        input  range, min_out, max_out, count, valid, busy, error
    );

    modport slave (
        input  go, finish, signed_mode, data_in,
        output range, min_out, max_out, count, valid, busy, error
    );
endinterface

// File: rtl/range_finder_mt.sv
// range_finder_mt: tracks min/max of a sampled stream between go and finish
// strobes, then reports range, min, max and sample count with a one-cycle
// valid pulse. Protocol violations park the block in ERR until the next go.
// Optional feature macro: RANGE_FINDER_MT_COUNT_EN enables the saturating
// sample counter; without it count is tied to zero.
module range_finder_mt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic              clock,
    input logic              reset_n,
    range_finder_mt_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t           state, state_next;
    logic             accept_go, accept_finish, take_sample, error_evt;
    logic             sgn;
    logic [WIDTH-1:0] cur_min, cur_max, new_min, new_max;
    logic [WIDTH-1:0] range_q, min_q, max_q;
    logic             valid_q;

    // Ordering compare in the mode latched at go.
    function automatic logic less_than(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic             s);
        return s ? ($signed(a) < $signed(b)) : (a < b);
    endfunction

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Decode strobes against the current state and pick the next state.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        accept_go     = 1'b0;
        accept_finish = 1'b0;
        take_sample   = 1'b0;
        error_evt     = 1'b0;
        state_next    = state;
        if (bus.go && bus.finish) begin
            error_evt = 1'b1;
        end else if (state == RUN) begin
            if (bus.go) begin
                error_evt = 1'b1;
            end else begin
                take_sample   = 1'b1;
                accept_finish = bus.finish;
            end
        end else begin
            if (bus.finish) error_evt = 1'b1;
            else            accept_go = bus.go;
        end
        if (error_evt)          state_next = ERR;
        else if (accept_go)     state_next = RUN;
        else if (accept_finish) state_next = IDLE;
    end

    // Candidate extremes including this cycle's sample.
    always_comb begin
        new_min = less_than(bus.data_in, cur_min, sgn) ? bus.data_in : cur_min;
        new_max = less_than(cur_max, bus.data_in, sgn) ? bus.data_in : cur_max;
    end

    // Running min/max and compare mode for the active run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_min <= '0;
            cur_max <= '0;
            sgn     <= 1'b0;
        end else if (accept_go) begin
            cur_min <= bus.data_in;
            cur_max <= bus.data_in;
            sgn     <= bus.signed_mode;
        end else if (take_sample) begin
            cur_min <= new_min;
            cur_max <= new_max;
        end
    end

    // Result registers: updated only by an accepted finish, held otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            range_q <= '0;
            min_q   <= '0;
            max_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept_finish;
            if (accept_finish) begin
                range_q <= new_max - new_min;
                min_q   <= new_min;
                max_q   <= new_max;
            end
        end
    end

`ifdef RANGE_FINDER_MT_COUNT_EN
    logic [CNT_W-1:0] cnt, cnt_inc, count_q;

    // Saturating increment: holds at all-ones instead of wrapping.
    always_comb cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // Sample counter and its reported copy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            count_q <= '0;
        end else begin
            if (accept_go)        cnt <= CNT_W'(1);
            else if (take_sample) cnt <= cnt_inc;
            if (accept_finish)    count_q <= cnt_inc;
        end
    end

    assign bus.count = count_q;
`else
    assign bus.count = '0;
`endif

    assign bus.range   = range_q;
    assign bus.min_out = min_q;
    assign bus.max_out = max_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = (state == RUN);
    assign bus.error   = (state == ERR);
endmodule

// File: tb/tb_range_finder_mt.sv
// tb_range_finder_mt: directed vectors with hand-computed results for
// range_finder_mt (WIDTH=8, CNT_W=4 so saturation is reachable quickly).
module tb_range_finder_mt;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
`ifdef RANGE_FINDER_MT_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    range_finder_mt_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    range_finder_mt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int exp_cnt(input int n);
        return COUNT_EN ? n : 0;
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic g, input logic f, input logic s,
                         input logic [WIDTH-1:0] d);
        bus.go          = g;
        bus.finish      = f;
        bus.signed_mode = s;
        bus.data_in     = d;
    endtask

    task automatic check_results(input string tag, input int mx, input int mn,
                                 input int rg, input int cn);
        check({tag, ".max"},   32'(bus.max_out), 32'(mx));
        check({tag, ".min"},   32'(bus.min_out), 32'(mn));
        check({tag, ".range"}, 32'(bus.range),   32'(rg));
        check({tag, ".count"}, 32'(bus.count),   32'(exp_cnt(cn)));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        check_results("reset", 0, 0, 0, 0);
        check("reset.valid", 32'(bus.valid), 0);
        check("reset.busy",  32'(bus.busy),  0);
        check("reset.error", 32'(bus.error), 0);
        #10 reset_n = 1'b1;
        step();

        // Unsigned run: 0x10, 0x80, 0x05, 0x40.
        drive(1'b1, 1'b0, 1'b0, 8'h10); step();
        check("u.busy_rise", 32'(bus.busy), 1);
        drive(1'b0, 1'b0, 1'b0, 8'h80); step();
        drive(1'b0, 1'b0, 1'b0, 8'h05); step();
        check("u.no_early_valid", 32'(bus.valid), 0);
        drive(1'b0, 1'b1, 1'b0, 8'h40); step();
        check("u.valid", 32'(bus.valid), 1);
        check("u.busy_fall", 32'(bus.busy), 0);
        check_results("u", 8'h80, 8'h05, 8'h7B, 4);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();
        check("u.valid_one_cycle", 32'(bus.valid), 0);

        // Signed run: mode latched at go, dropped afterwards.
        drive(1'b1, 1'b0, 1'b1, 8'h7F); step();
        drive(1'b0, 1'b0, 1'b0, 8'h80); step();
        drive(1'b0, 1'b1, 1'b0, 8'h00); step();
        check("s.valid", 32'(bus.valid), 1);
        check_results("s", 8'h7F, 8'h80, 8'hFF, 3);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();

        // finish in IDLE.
        drive(1'b0, 1'b1, 1'b0, 8'h11); step();
        check("e1.error", 32'(bus.error), 1);
        check("e1.valid", 32'(bus.valid), 0);
        check_results("e1", 8'h7F, 8'h80, 8'hFF, 3);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();
        check("e1.hold", 32'(bus.error), 1);
        // go from ERR recovers.
        drive(1'b1, 1'b0, 1'b0, 8'h20); step();
        check("e2.error", 32'(bus.error), 0);
        check("e2.busy",  32'(bus.busy),  1);
        // go during RUN.
        drive(1'b1, 1'b0, 1'b0, 8'h21); step();
        check("e3.error", 32'(bus.error), 1);
        check("e3.busy",  32'(bus.busy),  0);
        check("e3.valid", 32'(bus.valid), 0);
        check_results("e3", 8'h7F, 8'h80, 8'hFF, 3);

        // Clean run back to IDLE, then go+finish together.
        drive(1'b1, 1'b0, 1'b0, 8'h22); step();
        drive(1'b0, 1'b1, 1'b0, 8'h24); step();
        check_results("c", 8'h24, 8'h22, 8'h02, 2);
        drive(1'b1, 1'b1, 1'b0, 8'h99); step();
        check("gf.error", 32'(bus.error), 1);
        check("gf.valid", 32'(bus.valid), 0);
        check_results("gf", 8'h24, 8'h22, 8'h02, 2);

        // Reset mid-run between edges.
        drive(1'b1, 1'b0, 1'b0, 8'h50); step();
        drive(1'b0, 1'b0, 1'b0, 8'h60); step();
        #2 reset_n = 1'b0;
        #1;
        check_results("rst", 0, 0, 0, 0);
        check("rst.busy",  32'(bus.busy),  0);
        check("rst.valid", 32'(bus.valid), 0);
        #2 reset_n = 1'b1;
        step();
        check("rst.no_valid", 32'(bus.valid), 0);
        check("rst.idle", 32'(bus.busy), 0);
        drive(1'b1, 1'b0, 1'b0, 8'h09); step();
        drive(1'b0, 1'b1, 1'b0, 8'h03); step();
        check("rst.run_valid", 32'(bus.valid), 1);
        check_results("rst.run", 8'h09, 8'h03, 8'h06, 2);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();

        // 20-sample run saturates the 4-bit counter.
        drive(1'b1, 1'b0, 1'b0, 8'h00); step();
        for (int i = 1; i <= 18; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'(i)); step();
        end
        drive(1'b0, 1'b1, 1'b0, 8'h13); step();
        check("sat.valid", 32'(bus.valid), 1);
        check_results("sat", 8'h13, 8'h00, 8'h13, 15);
        // Back-to-back run starting the cycle after finish.
        drive(1'b1, 1'b0, 1'b0, 8'h33); step();
        check("b2b.busy", 32'(bus.busy), 1);
        check("b2b.valid_low", 32'(bus.valid), 0);
        drive(1'b0, 1'b1, 1'b0, 8'h33); step();
        check("b2b.valid", 32'(bus.valid), 1);
        check_results("b2b", 8'h33, 8'h33, 8'h00, 2);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
